// File: rtl/ebpc_act_serializer_pkg.sv
// Shared types and default widths for the EBPC activation serializer.
package ebpc_act_serializer_pkg;

    localparam int unsigned ACT_DATA_W     = 8;
    localparam int unsigned ACT_BEAT_WORDS = 4;
    localparam int unsigned FRAME_LEN_W    = 24;

    typedef logic [ACT_BEAT_WORDS-1:0][ACT_DATA_W-1:0] act_beat_t;

    typedef enum logic {
        SER_IDLE   = 1'b0,
        SER_ACTIVE = 1'b1
    } ser_state_e;

endpackage

// File: rtl/ebpc_act_serializer.sv
// Serializes wide activation beats into one word per cycle and flags the
// final word of each frame so the downstream encoder can flush.
module ebpc_act_serializer
    import ebpc_act_serializer_pkg::*;
#(
    parameter int unsigned DATA_W  = ACT_DATA_W,
    parameter int unsigned N_WORDS = ACT_BEAT_WORDS,
    parameter int unsigned LEN_W   = FRAME_LEN_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [LEN_W-1:0]          frame_len_i,
    input  logic [N_WORDS*DATA_W-1:0] data_i,
    input  logic                      vld_i,
    output logic                      rdy_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      last_o,
    output logic                      vld_o,
    input  logic                      rdy_i,
    output logic                      busy_o
);

    localparam int unsigned     IDX_W   = $clog2(N_WORDS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_WORDS - 1);

    ser_state_e                     r_state;
    ser_state_e                     w_state_nxt;
    logic [N_WORDS-1:0][DATA_W-1:0] r_beat;
    logic                           r_full;
    logic [IDX_W-1:0]               r_idx;
    logic [LEN_W-1:0]               r_cnt;
    logic [LEN_W-1:0]               r_len;

    logic w_idx_end;
    logic w_last;
    logic w_out_xfer;
    logic w_in_xfer;
    logic w_frame_start;
    logic w_beat_done;

    assign w_idx_end   = (r_idx == IDX_MAX);
    assign w_last      = r_full && (r_cnt == (r_len - LEN_W'(1)));
    assign w_out_xfer  = r_full && rdy_i;
    assign w_beat_done = w_idx_end || w_last;

    // Accept a new beat when empty, or when the current one drains this cycle.
    assign rdy_o         = !rst_i && (!r_full || (rdy_i && w_beat_done));
    assign w_in_xfer     = vld_i && rdy_o;
    assign w_frame_start = w_in_xfer && ((r_state == SER_IDLE) || (w_out_xfer && w_last));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= SER_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SER_IDLE: begin
                if (w_in_xfer) begin
                    w_state_nxt = SER_ACTIVE;
                end
            end
            SER_ACTIVE: begin
                // A beat accepted alongside the last word opens the next frame.
                if (w_out_xfer && w_last && !w_in_xfer) begin
                    w_state_nxt = SER_IDLE;
                end
            end
            default: w_state_nxt = SER_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        vld_o  = r_full;
        data_o = r_beat[r_idx];
        last_o = w_last;
        if (r_state == SER_ACTIVE) begin
            busy_o = 1'b1;
        end
    end

    // Beat buffer, sub-word index, frame counter and latched length.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_beat <= '0;
            r_full <= 1'b0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
        end else begin
            if (w_out_xfer) begin
                r_cnt <= r_cnt + LEN_W'(1);
                if (w_beat_done) begin
                    r_idx  <= '0;
                    r_full <= 1'b0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
            if (w_in_xfer) begin
                r_beat <= data_i;
                r_full <= 1'b1;
            end
            if (w_frame_start) begin
                r_len <= (frame_len_i == '0) ? LEN_W'(1) : frame_len_i;
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ebpc_act_serializer.sv
// Directed bench for ebpc_act_serializer: frame-level word model, per-cycle
// output compare with stall stability checks, and literal spot checks.
module tb_ebpc_act_serializer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [23:0] frame_len_i;
    logic [31:0] data_i;
    logic        vld_i;
    logic        rdy_o;
    logic [7:0]  data_o;
    logic        last_o;
    logic        vld_o;
    logic        rdy_i;
    logic        busy_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0]  exp_d[$];
    logic        exp_l[$];
    logic [31:0] feed_beats[$];
    logic [23:0] feed_lens[$];
    logic [7:0]  log_d[$];
    logic        log_l[$];
    int          log_c[$];

    logic abort    = 1'b0;
    int   rdy_mode = 0;

    ebpc_act_serializer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .frame_len_i (frame_len_i),
        .data_i      (data_i),
        .vld_i       (vld_i),
        .rdy_o       (rdy_o),
        .data_o      (data_o),
        .last_o      (last_o),
        .vld_o       (vld_o),
        .rdy_i       (rdy_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a frame is the beats' words, word 0 first, truncated to max(len,1).
    task automatic push_frame(input int len, input logic [31:0] beats [4]);
        int n;
        int nb;
        logic [31:0] b;
        n  = (len == 0) ? 1 : len;
        nb = (n + 3) / 4;
        for (int i = 0; i < n; i++) begin
            b = beats[i / 4];
            exp_d.push_back(b[8 * (i % 4) +: 8]);
            exp_l.push_back(i == n - 1);
        end
        for (int i = 0; i < nb; i++) begin
            feed_beats.push_back(beats[i]);
            feed_lens.push_back((i == 0) ? 24'(len) : 24'hABCDEF);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (k < 500) begin
            @(negedge clk);
            if (exp_d.size() == 0 && feed_beats.size() == 0 && !busy_o && !vld_o) break;
            k++;
        end
        check("drain_timeout", 32'(k >= 500), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Input driver: present queued beats back-to-back.
    initial begin
        logic acc;
        vld_i       = 1'b0;
        data_i      = '0;
        frame_len_i = '0;
        forever begin
            @(negedge clk);
            acc = vld_i && rdy_o && !rst_i;
            @(posedge clk);
            #1;
            if (acc && feed_beats.size() != 0) begin
                void'(feed_beats.pop_front());
                void'(feed_lens.pop_front());
            end
            if (abort) begin
                feed_beats.delete();
                feed_lens.delete();
                abort = 1'b0;
            end
            if (feed_beats.size() != 0) begin
                vld_i       = 1'b1;
                data_i      = feed_beats[0];
                frame_len_i = feed_lens[0];
            end else begin
                vld_i       = 1'b0;
                data_i      = '0;
                frame_len_i = 24'h000055;
            end
        end
    end

    // Output ready driver: always ready, or random stalls of 0..5 cycles.
    initial begin
        int stall;
        stall = 0;
        rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                rdy_i = 1'b1;
            end else if (stall > 0) begin
                rdy_i = 1'b0;
                stall--;
            end else begin
                rdy_i = 1'b1;
                stall = $urandom_range(0, 5);
            end
        end
    end

    // Per-cycle compare against the frame model.
    initial begin
        logic       hold;
        logic       was_last;
        logic       in_acc;
        logic       last_in_acc;
        logic [7:0] prev_d;
        logic       prev_l;
        hold = 1'b0;
        was_last = 1'b0;
        last_in_acc = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                hold     = 1'b0;
                was_last = 1'b0;
                continue;
            end
            if (was_last) check("busy_after_last", 32'(busy_o), 32'(last_in_acc));
            if (hold) begin
                check("stall_vld", 32'(vld_o), 32'd1);
                check("stall_data", 32'(data_o), 32'(prev_d));
                check("stall_last", 32'(last_o), 32'(prev_l));
            end
            if (!vld_o) check("last_without_vld", 32'(last_o), 32'd0);
            in_acc   = vld_i && rdy_o;
            was_last = 1'b0;
            if (vld_o && rdy_i) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_word", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    check("word_data", 32'(data_o), 32'(exp_d.pop_front()));
                    check("word_last", 32'(last_o), 32'(exp_l.pop_front()));
                end
                log_d.push_back(data_o);
                log_l.push_back(last_o);
                log_c.push_back(cyc);
                was_last    = last_o;
                last_in_acc = in_acc;
            end
            hold   = vld_o && !rdy_i;
            prev_d = data_o;
            prev_l = last_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vld", 32'(vld_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rdy", 32'(rdy_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Basic flow: 8 words, no bubble.
        base = log_d.size();
        push_frame(8, '{32'h04030201, 32'h08070605, 32'h0, 32'h0});
        wait_done();
        check("basic_count", 32'(log_d.size() - base), 32'd8);
        check("basic_w0", 32'(log_d[base]), 32'h01);
        check("basic_w7", 32'(log_d[base + 7]), 32'h08);
        check("basic_last7", 32'(log_l[base + 7]), 32'd1);
        check("basic_last6", 32'(log_l[base + 6]), 32'd0);
        check("basic_nobubble", 32'(log_c[base + 7] - log_c[base]), 32'd7);

        // Partial final beat: 07/08 dropped.
        base = log_d.size();
        push_frame(6, '{32'h04030201, 32'h08070605, 32'h0, 32'h0});
        wait_done();
        check("partial_count", 32'(log_d.size() - base), 32'd6);
        check("partial_w5", 32'(log_d[base + 5]), 32'h06);
        check("partial_last5", 32'(log_l[base + 5]), 32'd1);

        // Back-to-back frames of 3 and 5 words.
        base = log_d.size();
        push_frame(3, '{32'h0C0B0A09, 32'h0, 32'h0, 32'h0});
        push_frame(5, '{32'h14131211, 32'h18171615, 32'h0, 32'h0});
        wait_done();
        check("b2b_count", 32'(log_d.size() - base), 32'd8);
        check("b2b_last2", 32'(log_l[base + 2]), 32'd1);
        check("b2b_w3", 32'(log_d[base + 3]), 32'h11);
        check("b2b_last7", 32'(log_l[base + 7]), 32'd1);
        check("b2b_w7", 32'(log_d[base + 7]), 32'h15);
        check("b2b_nobubble", 32'(log_c[base + 7] - log_c[base]), 32'd7);

        // Backpressure with random stalls.
        rdy_mode = 1;
        base = log_d.size();
        push_frame(12, '{32'h24232221, 32'h28272625, 32'h2C2B2A29, 32'h0});
        wait_done();
        rdy_mode = 0;
        check("bp_count", 32'(log_d.size() - base), 32'd12);
        check("bp_w11", 32'(log_d[base + 11]), 32'h2C);
        check("bp_last11", 32'(log_l[base + 11]), 32'd1);

        // Length zero behaves as one word.
        base = log_d.size();
        push_frame(0, '{32'h44332211, 32'h0, 32'h0, 32'h0});
        wait_done();
        check("len0_count", 32'(log_d.size() - base), 32'd1);
        check("len0_w0", 32'(log_d[base]), 32'h11);
        check("len0_last", 32'(log_l[base]), 32'd1);

        // Reset after 5 words of a 16-word frame.
        base = log_d.size();
        push_frame(16, '{32'h34333231, 32'h38373635, 32'h3C3B3A39, 32'h403F3E3D});
        k = 0;
        while (k < 200) begin
            @(posedge clk);
            #1;
            if (log_d.size() - base >= 5) break;
            k++;
        end
        check("rst_mid_timeout", 32'(k >= 200), 32'd0);
        rst_i = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_vld", 32'(vld_o), 32'd0);
        check("rstmid_last", 32'(last_o), 32'd0);
        check("rstmid_busy", 32'(busy_o), 32'd0);
        check("rstmid_rdy", 32'(rdy_o), 32'd0);
        check("rstmid_count", 32'(log_d.size() - base), 32'd5);
        exp_d.delete();
        exp_l.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        base = log_d.size();
        push_frame(4, '{32'h54535251, 32'h0, 32'h0, 32'h0});
        wait_done();
        check("post_rst_count", 32'(log_d.size() - base), 32'd4);
        check("post_rst_w0", 32'(log_d[base]), 32'h51);
        check("post_rst_last2", 32'(log_l[base + 2]), 32'd0);
        check("post_rst_last3", 32'(log_l[base + 3]), 32'd1);

        check("model_drained", 32'(exp_d.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
